spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command/register controller that sits behind the byte-level SPI slave (`spiSlave`) and gives the SPI link a small addressed register file. It parses the received byte stream of each chip-select frame as a command byte plus data bytes, performs register writes and reads, and preloads the slave's transmit byte so read data shifts out on the following byte. Downstream logic reads the register file through a host port and is notified of every SPI write.

## Interface
Parameters:
- `ADDR_W`, 4: register address width; bits [ADDR_W-1:0] of the command byte select the register.
- `NUM_REGS`, 16: register count, must equal 2**ADDR_W.
- `IDLE_BYTE`, 8'h00: value driven on `tx_data` when no read is in progress.

Ports (clock and reset first):
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ss` in 1: chip select, active-low, synchronized to `clk` upstream.
- `rx_valid` in 1: one-cycle pulse from `spiSlave` `done`, meaning a byte has been received.
- `rx_data` in 8: received byte, from `spiSlave` `dout`, valid when `rx_valid` is high.
- `tx_data` out 8: byte to shift out next, to `spiSlave` `din`.
- `host_addr` in ADDR_W: host read address.
- `host_rdata` out 8: combinational read of `regs[host_addr]`.
- `wr_strobe` out 1: one-cycle pulse after each SPI register write.
- `wr_addr` out ADDR_W: address of the last write, held until the next write.
- `wr_data` out 8: data of the last write, held until the next write.
- `frame_bytes` out 8: bytes received in the current or last frame, saturating at 255.

## Operation
- Command byte, the first byte of a frame: bit7 = 1 for read, 0 for write. Bit6 = auto-increment enable. Bits [ADDR_W-1:0] = start address. Remaining bits are ignored.
- States:
  - IDLE: `ss` high.
  - CMD: `ss` low, waiting for the first byte.
  - WRITE: data bytes follow the command.
  - READ: dummy bytes follow the command.
- Transitions:
  - IDLE→CMD when `ss` is low.
  - CMD→WRITE or CMD→READ on `rx_valid`, according to bit7.
  - Any state→IDLE in the cycle after `ss` is sampled high.
- WRITE, on each `rx_valid`:
  - `regs[addr] <= rx_data`.
  - `wr_strobe`, `wr_addr` and `wr_data` update.
  - If auto-increment is set, `addr <= addr+1` modulo NUM_REGS, so address 15 wraps to 0. Otherwise the same register is rewritten.
- READ:
  - On the command byte, `tx_data <= regs[cmd_addr]`.
  - On each later `rx_valid`, the address advances if auto-increment is set, and `tx_data` reloads with the new address's value. Without auto-increment it reloads the same register, reflecting any host-independent change.
  - Incoming bytes during READ are ignored.
- `tx_data` returns to IDLE_BYTE on entry to IDLE or CMD.
- `frame_bytes` clears on the IDLE→CMD transition, increments on each accepted `rx_valid`, and saturates at 255.
- `rx_valid` is ignored while `ss` is high, including the cycle in which `ss` rises.
- Reset (`rst`=0 at a clock edge), including mid-frame:
  - state IDLE.
  - all `regs` 0.
  - `tx_data` = IDLE_BYTE.
  - `wr_strobe` 0, `wr_addr` 0, `wr_data` 0.
  - `frame_bytes` 0.
  - The in-progress frame is abandoned. Bytes arriving after reset is released, while `ss` is still low, are parsed as a new command once state passes through CMD. State enters CMD the first cycle after reset with `ss` low.

## Timing
- Register write latency: `rx_valid` at edge N → register updated at edge N, visible on `host_rdata` from cycle N+1. `wr_strobe` is high for cycle N+1 only.
- `tx_data` is registered and valid the cycle after `rx_valid`. The system requires at least 2 `clk` cycles between `done` and the next byte's first `sck` edge. This holds with `sck` ≤ clk/4.
- Back-to-back `rx_valid` on consecutive cycles must be handled with no byte lost.
- Write and host read of the same address in the same cycle: `host_rdata` shows the old value that cycle.

## Structure
- Shared package `spi_pkg`:
  - state enum (IDLE, CMD, WRITE, READ).
  - command bit positions `CMD_RD_BIT`=7 and `CMD_INC_BIT`=6.
  - `IDLE_BYTE` default.
- One sub-module, `spi_regfile`: NUM_REGS×8 array with synchronous write, active-low synchronous clear, and two combinational read ports (SPI read and host read).
- FSM, address counter and byte counter live in `spi_reg_ctrl`.

## Test plan
- Reset, then frame with write command 8'h43 followed by AA, BB, CC → regs[3..5] = AA, BB, CC; three `wr_strobe` pulses; `frame_bytes` = 4.
- Write command 8'h0F followed by 11, 22 (no auto-increment) → reg15 = 22, regs[0..14] unchanged; `wr_addr` = 15.
- Write command 8'h4F followed by 11, 22 → reg15 = 11 and reg0 = 22, confirming wrap-around.
- After the first test, read command 8'hC3 followed by 3 dummy bytes → `tx_data` sequence AA, BB, CC, then IDLE_BYTE after `ss` rises.
- Assert `rst`=0 mid-write frame after 1 data byte, release, keep `ss` low and send 8'h01 then 5A → all regs 0 except reg1 = 5A.
- `rx_valid` pulsed with `ss` high → no state, register or `frame_bytes` change.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register controller.
// Contents: FSM state enum, command byte bit positions, default idle byte.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WRITE = 2'd2,
      READ  = 2'd3
   } state_e;

   localparam int unsigned CMD_RD_BIT  = 7;
   localparam int unsigned CMD_INC_BIT = 6;

   localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

endpackage

// File: rtl/spi_regfile.sv
// Register array behind the SPI command controller.
// Ports:
//   clk        - system clock
//   clr_n_i    - synchronous active-low clear of every register
//   we_i       - write enable, writes wdata_i to regs[waddr_i]
//   waddr_i    - write address
//   wdata_i    - write data
//   spi_addr_i - SPI-side read address, spi_rdata_o combinational
//   host_addr_i- host-side read address, host_rdata_o combinational
module spi_regfile #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              clr_n_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] spi_addr_i,
   output logic [7:0]        spi_rdata_o,
   input  logic [ADDR_W-1:0] host_addr_i,
   output logic [7:0]        host_rdata_o
);

   logic [7:0] regs_q [NUM_REGS];

   // Clear has priority over a write in the same cycle.
   always_ff @(posedge clk) begin
      if (!clr_n_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign spi_rdata_o  = regs_q[spi_addr_i];
   assign host_rdata_o = regs_q[host_addr_i];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind a byte-level SPI slave.
// Each chip-select frame is a command byte (bit7 read, bit6 auto-increment,
// low bits address) followed by write data or read dummy bytes.
// Ports:
//   clk, rst         - clock, synchronous active-low reset
//   ss               - chip select (active-low, already synchronized)
//   rx_valid/rx_data - received byte strobe and value
//   tx_data          - next byte to shift out (registered)
//   host_addr        - host read address; host_rdata combinational
//   wr_strobe/addr/data - pulse and record of the last SPI write
//   frame_bytes      - bytes accepted in current/last frame, saturating
module spi_reg_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic [7:0]        tx_data,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [7:0]        host_rdata,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [7:0]        frame_bytes
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                inc_q, inc_d;
   logic [7:0]          tx_q, tx_d;
   logic                wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic [7:0]          frame_q, frame_d;

   logic                accept_c;
   logic                we_c;
   logic [ADDR_W-1:0]   rd_addr_c;
   logic [7:0]          rd_data_c;
   logic                unused_cmd_bits;

   // Bits between the address field and the flag bits carry no meaning.
   assign unused_cmd_bits = ^rx_data;

   // A byte counts only while selected and past IDLE, so a byte racing ss rise is dropped.
   assign accept_c = rx_valid && !ss && (state_q != IDLE);

   // SPI read address: command address on the command byte, else the next read address.
   assign rd_addr_c = (state_q == CMD) ? rx_data[ADDR_W-1:0]
                                       : (inc_q ? addr_q + ADDR_W'(1) : addr_q);

   spi_regfile #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk          (clk),
      .clr_n_i      (rst),
      .we_i         (we_c),
      .waddr_i      (addr_q),
      .wdata_i      (rx_data),
      .spi_addr_i   (rd_addr_c),
      .spi_rdata_o  (rd_data_c),
      .host_addr_i  (host_addr),
      .host_rdata_o (host_rdata)
   );

   // Next-state and datapath decode.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      inc_d       = inc_q;
      tx_d        = tx_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_d     = frame_q;
      we_c        = 1'b0;

      case (state_q)
         IDLE: begin
            if (!ss) begin
               state_d = CMD;
               frame_d = 8'h00;
            end
         end
         CMD: begin
            if (accept_c) begin
               addr_d = rx_data[ADDR_W-1:0];
               inc_d  = rx_data[CMD_INC_BIT];
               if (rx_data[CMD_RD_BIT]) begin
                  state_d = READ;
                  tx_d    = rd_data_c;
               end else begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (accept_c) begin
               we_c        = 1'b1;
               wr_strobe_d = 1'b1;
               wr_addr_d   = addr_q;
               wr_data_d   = rx_data;
               if (inc_q) addr_d = addr_q + ADDR_W'(1);
            end
         end
         READ: begin
            if (accept_c) begin
               addr_d = rd_addr_c;
               tx_d   = rd_data_c;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept_c && (frame_q != 8'hFF)) frame_d = frame_q + 8'd1;

      if (ss) state_d = IDLE;

      if ((state_d == IDLE) || (state_d == CMD)) tx_d = IDLE_BYTE;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         inc_q       <= 1'b0;
         tx_q        <= IDLE_BYTE;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         frame_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         inc_q       <= inc_d;
         tx_q        <= tx_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_q     <= frame_d;
      end
   end

   assign tx_data     = tx_q;
   assign wr_strobe   = wr_strobe_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_bytes = frame_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: write/read frames, wrap, reset mid-frame, ss gating.
module tb_spi_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ss;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic [3:0] host_addr;
   logic [7:0] host_rdata;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] frame_bytes;

   int total = 0;
   int bad   = 0;
   int strobe_cnt = 0;

   spi_reg_ctrl #(
      .ADDR_W    (4),
      .NUM_REGS  (16),
      .IDLE_BYTE (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ss          (ss),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_data     (tx_data),
      .host_addr   (host_addr),
      .host_rdata  (host_rdata),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_bytes (frame_bytes)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) strobe_cnt++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present one byte for exactly one cycle; returns in the cycle after capture.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic chk_reg(input int a, input logic [7:0] exp);
      @(negedge clk);
      host_addr = 4'(a);
      #1;
      chk($sformatf("reg%0d", a), host_rdata, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; ss = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; host_addr = 4'h0;
      cycles(3);
      chk("rst_tx", tx_data, 8'hA5);
      chk("rst_strobe", {7'b0, wr_strobe}, 8'h00);
      chk("rst_wr_addr", {4'b0, wr_addr}, 8'h00);
      chk("rst_wr_data", wr_data, 8'h00);
      chk("rst_frame", frame_bytes, 8'h00);
      for (int i = 0; i < 16; i++) chk_reg(i, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      cycles(2);

      // Write 43: auto-increment from address 3.
      ss = 1'b0;
      cycles(2);
      chk("cmd_tx_idle", tx_data, 8'hA5);
      send_byte(8'h43);
      cycles(1);
      send_byte(8'hAA);
      chk("w1_strobe_hi", {7'b0, wr_strobe}, 8'h01);
      host_addr = 4'd3;
      #1;
      chk("w1_host_rdata", host_rdata, 8'hAA);
      cycles(1);
      send_byte(8'hBB);
      cycles(1);
      send_byte(8'hCC);
      cycles(1);
      chk("w1_frame", frame_bytes, 8'd4);
      chk("w1_strobes", 8'(strobe_cnt), 8'd3);
      chk("w1_wr_addr", {4'b0, wr_addr}, 8'h05);
      chk("w1_wr_data", wr_data, 8'hCC);
      ss = 1'b1;
      cycles(2);
      chk_reg(3, 8'hAA);
      chk_reg(4, 8'hBB);
      chk_reg(5, 8'hCC);

      // Read C3: auto-increment read from address 3.
      @(negedge clk);
      ss = 1'b0;
      cycles(2);
      send_byte(8'hC3);
      chk("rd_tx0", tx_data, 8'hAA);
      cycles(1);
      send_byte(8'h00);
      chk("rd_tx1", tx_data, 8'hBB);
      cycles(1);
      send_byte(8'h00);
      chk("rd_tx2", tx_data, 8'hCC);
      cycles(1);
      send_byte(8'h00);
      chk("rd_tx3", tx_data, 8'h00);
      chk("rd_frame", frame_bytes, 8'd4);
      ss = 1'b1;
      cycles(1);
      chk("rd_tx_idle", tx_data, 8'hA5);
      chk("rd_no_strobe", 8'(strobe_cnt), 8'd3);
      cycles(1);

      // Write 0F, no increment, back-to-back bytes.
      ss = 1'b0;
      cycles(2);
      send_byte(8'h0F);
      send_byte(8'h11);
      send_byte(8'h22);
      cycles(1);
      ss = 1'b1;
      cycles(2);
      chk("w2_wr_addr", {4'b0, wr_addr}, 8'h0F);
      chk("w2_wr_data", wr_data, 8'h22);
      chk("w2_strobes", 8'(strobe_cnt), 8'd5);
      chk_reg(15, 8'h22);
      chk_reg(14, 8'h00);
      chk_reg(0, 8'h00);
      chk_reg(3, 8'hAA);
      chk_reg(5, 8'hCC);

      // Write 4F with increment: 15 wraps to 0.
      @(negedge clk);
      ss = 1'b0;
      cycles(2);
      send_byte(8'h4F);
      cycles(1);
      send_byte(8'h11);
      cycles(1);
      send_byte(8'h22);
      cycles(1);
      ss = 1'b1;
      cycles(2);
      chk_reg(15, 8'h11);
      chk_reg(0, 8'h22);
      chk("w3_wr_addr", {4'b0, wr_addr}, 8'h00);
      chk("w3_strobes", 8'(strobe_cnt), 8'd7);

      // Reset mid-frame, then a new command with ss held low.
      @(negedge clk);
      ss = 1'b0;
      cycles(2);
      send_byte(8'h42);
      cycles(1);
      send_byte(8'h77);
      cycles(1);
      rst = 1'b0;
      cycles(1);
      chk("mrst_tx", tx_data, 8'hA5);
      chk("mrst_frame", frame_bytes, 8'h00);
      chk("mrst_wr_addr", {4'b0, wr_addr}, 8'h00);
      chk("mrst_wr_data", wr_data, 8'h00);
      chk("mrst_strobe", {7'b0, wr_strobe}, 8'h00);
      rst = 1'b1;
      cycles(2);
      send_byte(8'h01);
      cycles(1);
      send_byte(8'h5A);
      cycles(1);
      for (int i = 0; i < 16; i++) chk_reg(i, (i == 1) ? 8'h5A : 8'h00);
      chk("mrst_frame2", frame_bytes, 8'd2);

      // Byte arriving in the same cycle ss rises is dropped.
      @(negedge clk);
      ss       = 1'b1;
      rx_data  = 8'hEE;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      cycles(1);
      chk("ssrise_frame", frame_bytes, 8'd2);
      chk("ssrise_wr_data", wr_data, 8'h5A);
      chk("ssrise_strobes", 8'(strobe_cnt), 8'd9);
      chk_reg(1, 8'h5A);

      // Bytes with ss high are ignored entirely.
      @(negedge clk);
      send_byte(8'h03);
      cycles(1);
      send_byte(8'h99);
      cycles(1);
      chk("sshi_frame", frame_bytes, 8'd2);
      chk("sshi_tx", tx_data, 8'hA5);
      chk("sshi_strobes", 8'(strobe_cnt), 8'd9);
      chk_reg(1, 8'h5A);
      chk_reg(3, 8'h00);

      // New frame entry clears the byte counter.
      @(negedge clk);
      ss = 1'b0;
      cycles(2);
      chk("newframe_clear", frame_bytes, 8'h00);
      ss = 1'b1;
      cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
